// File: rtl/mips_xlat_pkg.sv
// mips_xlat_pkg: shared MIPS word, fetch-buffer entry and fetch-buffer state types
package mips_xlat_pkg;
  localparam int MIPS_INSTR_W = 32;
  typedef logic [MIPS_INSTR_W-1:0] mips_word_t;
  localparam mips_word_t MIPS_NOP = 32'h0000_0000;
  typedef struct packed {
    mips_word_t  instr;
    logic [31:0] pc;
  } fb_entry_t;
  typedef enum logic [1:0] {FB_EMPTY, FB_ACTIVE, FB_FULL} fb_state_t;
endpackage

// File: rtl/mips_fetch_buffer.sv
// mips_fetch_buffer: show-ahead circular buffer of {instr,pc} between fetch (fetch_*) and translator (mips_*, instruction_ready), with flush and occupancy
module mips_fetch_buffer
  import mips_xlat_pkg::*;
#(
  parameter int         DEPTH    = 4,
  parameter int         PTR_W    = $clog2(DEPTH),
  parameter mips_word_t NOP_WORD = MIPS_NOP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_valid,
  output logic             fetch_ready,
  input  logic [31:0]      fetch_instr,
  input  logic [31:0]      fetch_pc,
  input  logic             flush,
  output logic [31:0]      mips_instruction,
  output logic [31:0]      mips_pc,
  output logic             mips_valid,
  input  logic             instruction_ready,
  output logic [PTR_W:0]   occupancy
);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] CNT_LAST = (PTR_W+1)'(DEPTH - 1);
  fb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  fb_state_t        st_q, st_d;
  logic             push, pop;
  assign fetch_ready      = (st_q != FB_FULL) & ~flush & ~reset;
  assign mips_valid       = st_q != FB_EMPTY;
  assign push             = fetch_valid & fetch_ready;
  assign pop              = mips_valid & instruction_ready;
  assign mips_instruction = mips_valid ? mem_q[rd_q].instr : NOP_WORD;
  assign mips_pc          = mips_valid ? mem_q[rd_q].pc : 32'h0;
  assign occupancy        = cnt_q;
  always_comb begin
    wr_d  = flush ? '0 : wr_q + PTR_W'(push);
    rd_d  = flush ? '0 : rd_q + PTR_W'(pop);
    cnt_d = flush ? '0 : cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    st_d  = st_q;
    case (st_q)
      FB_EMPTY:  st_d = push ? FB_ACTIVE : FB_EMPTY;
      FB_ACTIVE: st_d = (pop & ~push & cnt_q == CNT_ONE) ? FB_EMPTY :
                        (push & ~pop & cnt_q == CNT_LAST) ? FB_FULL : FB_ACTIVE;
      FB_FULL:   st_d = pop ? FB_ACTIVE : FB_FULL;
      default:   st_d = FB_EMPTY;
    endcase
    if (flush) st_d = FB_EMPTY;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      st_q  <= FB_EMPTY;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      st_q  <= st_d;
    end
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= '{instr: fetch_instr, pc: fetch_pc};
endmodule

// File: tb/tb_mips_fetch_buffer.sv
// tb_mips_fetch_buffer: directed and random stimulus against a queue model of the fetch buffer
module tb_mips_fetch_buffer;
  localparam int DEPTH = 4;
  logic        clk = 1'b0;
  logic        reset, fetch_valid, fetch_ready, flush, mips_valid, instruction_ready;
  logic [31:0] fetch_instr, fetch_pc, mips_instruction, mips_pc;
  logic [2:0]  occupancy;
  int          n_cmp = 0, n_bad = 0;
  logic [63:0] q [$];
  logic [31:0] src_i = 32'h0, src_p = 32'h0;
  mips_fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_instr(fetch_instr), .fetch_pc(fetch_pc), .flush(flush),
    .mips_instruction(mips_instruction), .mips_pc(mips_pc), .mips_valid(mips_valid),
    .instruction_ready(instruction_ready), .occupancy(occupancy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic fv, input logic rdy, input logic fl, input logic rs);
    logic e_rdy, e_push, e_pop;
    fetch_valid = fv; fetch_instr = src_i; fetch_pc = src_p;
    instruction_ready = rdy; flush = fl; reset = rs;
    #4;
    e_rdy  = (q.size() < DEPTH) && !fl && !rs;
    e_push = fv && e_rdy;
    e_pop  = (q.size() > 0) && rdy;
    check("fetch_ready", {31'b0, fetch_ready}, {31'b0, e_rdy});
    check("mips_valid", {31'b0, mips_valid}, {31'b0, q.size() > 0});
    check("mips_instruction", mips_instruction, q.size() > 0 ? q[0][63:32] : 32'h0);
    check("mips_pc", mips_pc, q.size() > 0 ? q[0][31:0] : 32'h0);
    check("occupancy", {29'b0, occupancy}, 32'(q.size()));
    if (rs || fl) q.delete();
    else begin
      if (e_pop) void'(q.pop_front());
      if (e_push) q.push_back({src_i, src_p});
    end
    if (e_push) begin
      src_i = $urandom;
      src_p = src_p + 32'd4;
    end
    @(posedge clk); #1;
  endtask
  initial begin
    reset = 1'b1; fetch_valid = 1'b0; flush = 1'b0; instruction_ready = 1'b0;
    fetch_instr = '0; fetch_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    step(0, 0, 0, 1);
    src_i = 32'h0022_1820; src_p = 32'h100;
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    src_i = 32'h2022_800A;
    repeat (5) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(1, i[0], 0, 0);
    for (int i = 0; i < 8 && q.size() > 0; i++) step(0, 1, 0, 0);
    repeat (2) step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0);
    for (int i = 0; i < 8 && q.size() > 0; i++) step(0, 1, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    step(0, 0, 0, 0);
    repeat (4) step(1, 0, 0, 0);
    step(1, 1, 0, 1);
    step(0, 0, 0, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(3) != 0, $urandom_range(2) != 0,
           $urandom_range(19) == 0, $urandom_range(49) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
